// File: rtl/button_debounce_bank.sv
// Multi-channel button debouncer with a shared sample-tick prescaler and press/release pulses.
// Define DEB_AUTOREPEAT_EN to add per-channel auto-repeat press pulses while a button is held.
module button_debounce_bank #(
    parameter int              N_CH         = 5,
    parameter int              SAMPLE_DIV   = 100000,
    parameter int              STABLE_TICKS = 8,
    parameter logic [N_CH-1:0] IN_INVERT    = '0,
    parameter int              REPEAT_DELAY = 40,
    parameter int              REPEAT_RATE  = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic            any_press
);

    localparam int              DIV_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SAMPLE_DIV - 1);
    localparam int              CNT_W   = $clog2(STABLE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_TICKS - 1);

    logic [N_CH-1:0]  meta_q;
    logic [N_CH-1:0]  sync_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  btn_level_q, btn_level_d;
    logic [N_CH-1:0]  rise_d;
    logic [N_CH-1:0]  btn_press_q, btn_press_d;
    logic [N_CH-1:0]  btn_release_q, btn_release_d;
    logic             any_press_q, any_press_d;

    always_comb begin
        tick  = (div_q == DIV_MAX);
        div_d = tick ? '0 : div_q + 1'b1;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i]         = cnt_q[i];
            btn_level_d[i]   = btn_level_q[i];
            rise_d[i]        = 1'b0;
            btn_release_d[i] = 1'b0;
            if (tick) begin
                if (sync_q[i] != btn_level_q[i]) begin
                    if (cnt_q[i] == CNT_MAX) begin
                        btn_level_d[i]   = sync_q[i];
                        cnt_d[i]         = '0;
                        rise_d[i]        = sync_q[i];
                        btn_release_d[i] = ~sync_q[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end else begin
                    // Agreement with the accepted level means the input bounced back.
                    cnt_d[i] = '0;
                end
            end
        end
    end

`ifdef DEB_AUTOREPEAT_EN
    localparam int              REP_W      = $clog2(REPEAT_DELAY + 1);
    localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_RATE);

    logic [REP_W-1:0] rep_q [N_CH];
    logic [REP_W-1:0] rep_d [N_CH];
    logic [N_CH-1:0]  rep_fire;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            rep_d[i]    = rep_q[i];
            rep_fire[i] = 1'b0;
            // Cleared while released, on the press edge and on the release edge.
            if (!btn_level_q[i] || !btn_level_d[i]) begin
                rep_d[i] = '0;
            end else if (tick) begin
                if (rep_q[i] == REP_LAST) begin
                    rep_fire[i] = 1'b1;
                    rep_d[i]    = REP_RELOAD;
                end else begin
                    rep_d[i] = rep_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) rep_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) rep_q[i] <= rep_d[i];
        end
    end

    assign btn_press_d = rise_d | rep_fire;
`else
    assign btn_press_d = rise_d;
`endif

    assign any_press_d = |btn_press_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q        <= '0;
            sync_q        <= '0;
            div_q         <= '0;
            btn_level_q   <= '0;
            btn_press_q   <= '0;
            btn_release_q <= '0;
            any_press_q   <= 1'b0;
            // NOTE: the counter array is a handful of flops, not RAM, so resetting it costs nothing.
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
        end else begin
            meta_q        <= btn_in ^ IN_INVERT;
            sync_q        <= meta_q;
            div_q         <= div_d;
            btn_level_q   <= btn_level_d;
            btn_press_q   <= btn_press_d;
            btn_release_q <= btn_release_d;
            any_press_q   <= any_press_d;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign btn_level   = btn_level_q;
    assign btn_press   = btn_press_q;
    assign btn_release = btn_release_q;
    assign any_press   = any_press_q;

endmodule

// File: tb/tb_button_debounce_bank.sv
// Directed bench for button_debounce_bank: table-driven windows plus hand-written latency,
// bounce, reset-mid-hold and long-hold (auto-repeat when DEB_AUTOREPEAT_EN) sequences.
module tb_button_debounce_bank;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] btn_in = 5'b11111;
    logic [N-1:0] btn_level, btn_press, btn_release;
    logic         any_press;

    always #5 clk = ~clk;

    button_debounce_bank #(
        .N_CH(N), .SAMPLE_DIV(4), .STABLE_TICKS(3), .IN_INVERT(5'b00000),
        .REPEAT_DELAY(5), .REPEAT_RATE(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .btn_level(btn_level),
        .btn_press(btn_press), .btn_release(btn_release), .any_press(any_press)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor: cumulative pulse counts sampled on the falling edge, plus sticky protocol flags.
    int press_tot [N] = '{default: 0};
    int rel_tot   [N] = '{default: 0};
    int any_tot = 0;
    int cyc = 0;
    int press3_t [$];
    bit both_seen = 1'b0;
    bit any_bad   = 1'b0;
    bit rst_dirty = 1'b0;

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (btn_press[i])   press_tot[i]++;
            if (btn_release[i]) rel_tot[i]++;
        end
        if (any_press) any_tot++;
        if (btn_press[3]) press3_t.push_back(cyc);
        if (|(btn_press & btn_release)) both_seen = 1'b1;
        if (any_press !== (|btn_press)) any_bad = 1'b1;
        if (!rst_n && ({btn_level, btn_press, btn_release, any_press} != '0)) rst_dirty = 1'b1;
    end

    int p0 [N];
    int r0 [N];
    int a0;

    task automatic snap();
        for (int i = 0; i < N; i++) begin
            p0[i] = press_tot[i];
            r0[i] = rel_tot[i];
        end
        a0 = any_tot;
    endtask

    task automatic drive(input logic [N-1:0] v);
        @(posedge clk);
        #1 btn_in = v;
    endtask

    // Counts rising edges until btn_level[ch] == val; sampled 1 time unit after each edge.
    task automatic wait_bit(input int ch, input logic val, input int max, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int k = 0; k < max; k++) begin
            @(posedge clk);
            n++;
            #1;
            if (btn_level[ch] == val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [N-1:0] btn;
        int           cycles;
        logic [N-1:0] exp_level;
        logic [N-1:0] exp_press;
        logic [N-1:0] exp_rel;
        int           exp_any;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int  n, n2, exp_p;
        bit  ok;
        int  q0;

        vecs[0] = '{5'b00000, 30, 5'b00000, 5'b00000, 5'b11111, 0};
        vecs[1] = '{5'b00001, 30, 5'b00001, 5'b00001, 5'b00000, 1};
        vecs[2] = '{5'b00000, 30, 5'b00000, 5'b00000, 5'b00001, 0};
        vecs[3] = '{5'b01000,  6, 5'b00000, 5'b00000, 5'b00000, 0};
        vecs[4] = '{5'b00000, 30, 5'b00000, 5'b00000, 5'b00000, 0};
        vecs[5] = '{5'b10100, 30, 5'b10100, 5'b10100, 5'b00000, 1};
        vecs[6] = '{5'b00000, 30, 5'b10100, 5'b00000, 5'b10100, 0};
        vecs[6].exp_level = 5'b00000;

        // Reset held with all buttons pressed, then released.
        #2 rst_n = 1'b0;
        repeat (6) @(posedge clk);
        #1 check("reset_outputs_zero", int'({btn_level, btn_press, btn_release, any_press}), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        snap();
        n  = 0;
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            n++;
            #1;
            if (btn_level == 5'b11111) begin
                ok = 1'b1;
                break;
            end
        end
        check("reset_release_level_reached", int'(ok), 1);
        check_range("reset_release_latency", n, 11, 14);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check($sformatf("reset_release_press_ch%0d", i), press_tot[i] - p0[i], 1);
            check($sformatf("reset_release_rel_ch%0d", i), rel_tot[i] - r0[i], 0);
        end
        check("reset_release_any_cycles", any_tot - a0, 1);

        // Table-driven windows.
        for (int v = 0; v < 7; v++) begin
            drive(vecs[v].btn);
            snap();
            repeat (vecs[v].cycles) @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_level", v), int'(btn_level), int'(vecs[v].exp_level));
            for (int i = 0; i < N; i++) begin
                check($sformatf("vec%0d_press_ch%0d", v, i), press_tot[i] - p0[i], int'(vecs[v].exp_press[i]));
                check($sformatf("vec%0d_rel_ch%0d", v, i), rel_tot[i] - r0[i], int'(vecs[v].exp_rel[i]));
            end
            check($sformatf("vec%0d_any_cycles", v), any_tot - a0, vecs[v].exp_any);
        end

        // Channel 0: press latency, 100-cycle hold, release latency.
        snap();
        drive(5'b00001);
        wait_bit(0, 1'b1, 30, n, ok);
        check("ch0_rise_seen", int'(ok), 1);
        check_range("ch0_rise_latency", n, 11, 14);
        check("ch0_press_with_rise", int'(btn_press[0]), 1);
        repeat (100 - n) @(posedge clk);
        #1 btn_in = 5'b00000;
        wait_bit(0, 1'b0, 30, n2, ok);
        check("ch0_fall_seen", int'(ok), 1);
        check_range("ch0_fall_latency", n2, 11, 14);
        check("ch0_release_with_fall", int'(btn_release[0]), 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        exp_p = 1;
`ifdef DEB_AUTOREPEAT_EN
        for (int t = n + 20; t < 100 + n2; t += 8) exp_p++;
`endif
        check("ch0_press_count", press_tot[0] - p0[0], exp_p);
        check("ch0_release_count", rel_tot[0] - r0[0], 1);

        // Channel 1: bounce every 3 cycles for 30 cycles, then settle high.
        snap();
        for (int k = 0; k < 10; k++) begin
            btn_in[1] = (k % 2 == 0);
            repeat (3) @(posedge clk);
            #1;
        end
        btn_in[1] = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("bounce_press_count", press_tot[1] - p0[1], 1);
        check("bounce_release_count", rel_tot[1] - r0[1], 0);
        check("bounce_level", int'(btn_level[1]), 1);
        drive(5'b00000);
        repeat (30) @(posedge clk);

        // Channel 0: one-cycle reset pulse while held.
        drive(5'b00001);
        repeat (30) @(posedge clk);
        #1 check("midhold_level_before", int'(btn_level[0]), 1);
        snap();
        rst_n = 1'b0;
        #1 check("midhold_async_clear", int'({btn_level, btn_press, btn_release, any_press}), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_bit(0, 1'b1, 30, n, ok);
        check("midhold_repress_seen", int'(ok), 1);
        check_range("midhold_repress_latency", n, 11, 14);
        check("midhold_press_with_rise", int'(btn_press[0]), 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midhold_press_count", press_tot[0] - p0[0], 1);
        check("midhold_release_count", rel_tot[0] - r0[0], 0);
        drive(5'b00000);
        repeat (30) @(posedge clk);

        // Channel 3: 200-cycle hold.
        snap();
        q0 = press3_t.size();
        drive(5'b01000);
        repeat (200) @(posedge clk);
        drive(5'b00000);
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("hold_release_count", rel_tot[3] - r0[3], 1);
        check("hold_level_after", int'(btn_level[3]), 0);
`ifdef DEB_AUTOREPEAT_EN
        if (press3_t.size() - q0 >= 4) begin
            check("repeat_first_gap", press3_t[q0 + 1] - press3_t[q0], 20);
            check("repeat_gap2", press3_t[q0 + 2] - press3_t[q0 + 1], 8);
            check("repeat_gap3", press3_t[q0 + 3] - press3_t[q0 + 2], 8);
        end else begin
            check("repeat_pulse_count", press3_t.size() - q0, 4);
        end
`else
        check("hold_press_count", press_tot[3] - p0[3], 1);
`endif

        check("never_press_and_release", int'(both_seen), 0);
        check("any_press_matches_or", int'(any_bad), 0);
        check("outputs_zero_in_reset", int'(rst_dirty), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/button_debounce_bank.md
Name: button_debounce_bank

Overview:
- Parametrised multi-channel debouncer with edge detection; replaces the per-button single-channel debouncer instances in the game top level.
- One instance serves all front-panel buttons (default 5: up, down, left, right, centre).
- Provides a clean level, a one-cycle press pulse and a one-cycle release pulse per channel to the game-control FSM.
- Uses a shared sample-tick prescaler, so no derived debounce clock is needed.

Parameters:
- N_CH, 5: number of button channels (1..32).
- SAMPLE_DIV, 100000: clk cycles per sample tick (>=1; 1 = tick every cycle).
- STABLE_TICKS, 8: consecutive disagreeing ticks required to accept a new level (>=1).
- IN_INVERT, 0: N_CH-bit mask; bit i=1 means channel i pin is active-low.
- REPEAT_DELAY, 40: ticks of hold before the first auto-repeat (used only with the optional feature).
- REPEAT_RATE, 10: ticks between auto-repeats (used only with the optional feature).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- btn_in  in  N_CH  raw asynchronous button pins.
- btn_level  out  N_CH  debounced level, 1 = pressed.
- btn_press  out  N_CH  one-cycle pulse on accepted press (and on repeats when enabled).
- btn_release  out  N_CH  one-cycle pulse on accepted release.
- any_press  out  1  OR of btn_press.

Interface decision: one clock, clk; reset rst_n is asynchronous and active-low.

Behaviour:
- **Reset.** rst_n low immediately clears everything: synchronisers, prescaler, per-channel counters, btn_level, btn_press, btn_release, any_press all = 0. Takes effect mid-operation with no pending pulse emitted. After release, a still-held button is treated as a new press and goes through full debounce.
- **Input conditioning.** btn_in XOR IN_INVERT feeds a 2-flop synchroniser per channel, reset value 0.
- **Prescaler.** Counter runs 0..SAMPLE_DIV-1. tick=1 for one cycle when the count equals SAMPLE_DIV-1, then the count wraps to 0. Free-running from reset release.
- **Per-channel counter** cnt, width clog2(STABLE_TICKS+1). Updates only on tick:
  - sync != btn_level and cnt == STABLE_TICKS-1: btn_level <= sync, cnt <= 0.
  - sync != btn_level otherwise: cnt <= cnt+1.
  - sync == btn_level: cnt <= 0 (any bounce back restarts the count).
  - Off-tick: cnt and btn_level hold.
- **Latency.** From pin edge to btn_level change: min 2+(STABLE_TICKS-1)*SAMPLE_DIV+1, max 2+STABLE_TICKS*SAMPLE_DIV cycles.
- **Pulses.** btn_press[i] and btn_release[i] are registered and high for exactly the one cycle that coincides with the edge where btn_level[i] rises or falls, respectively. Never both in the same cycle.
- **Multiple channels.** Channels are fully independent. Simultaneous presses produce simultaneous pulses, and any_press is a single cycle.
- **Counter bound.** cnt never exceeds STABLE_TICKS-1. No wrap is possible.

Optional Feature:
- Macro: DEB_AUTOREPEAT_EN.
- **Defined:** each channel has a repeat counter, cleared while btn_level=0 and on the press edge, and incremented on tick while btn_level=1.
  - When it reaches REPEAT_DELAY, btn_press pulses one cycle and the counter reloads to REPEAT_DELAY-REPEAT_RATE.
  - Result: further pulses every REPEAT_RATE ticks while held.
  - Release clears the counter; no repeat pulse is emitted in the release cycle.
- **Undefined:** btn_press fires only on the level rise. The repeat counters and parameters are not synthesised.

Test Plan (N_CH=5, SAMPLE_DIV=4, STABLE_TICKS=3, IN_INVERT=0):
- Hold rst_n=0 with btn_in=5'b11111 -> all outputs 0 throughout. Release reset -> btn_level=5'b11111 after 11..14 cycles, with one press pulse per channel.
- btn_in[0] 0->1, held 100 cycles, then 1->0 -> btn_level[0] rises 11..14 cycles after the edge with exactly one btn_press[0]; on release, exactly one btn_release[0] 11..14 cycles later.
- btn_in[1] toggles every 3 cycles for 30 cycles, then settles at 1 -> exactly one btn_press[1], zero btn_release[1], btn_level[1]=1.
- btn_in[3] high for 6 cycles only -> btn_level[3] stays 0; no pulses.
- btn_in[2] and btn_in[4] rise in the same cycle -> btn_press[2] and btn_press[4] in the same cycle; any_press high exactly 1 cycle.
- Covering reset mid-hold and auto-repeat:
  - With btn_level[0]=1, pulse rst_n low for 1 cycle while the pin is held -> outputs clear immediately, then re-press after 11..14 cycles.
  - With DEB_AUTOREPEAT_EN, REPEAT_DELAY=5, REPEAT_RATE=2, and a 200-cycle hold -> first repeat 20 cycles after the press pulse, then one every 8 cycles.
